// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the integer register file's single write port between the in-order
// pipeline writeback (port A) and a long-latency result source (port B).
// Port B results wait in a small FIFO and drain when the write port is free.
// A newer pipeline write to a register kills any older buffered write to the
// same register, so write-after-write order is preserved.
//
// Optional feature macro: WBARB_STARVE_EN
//   defined   : starve counter; B is force-granted after STARVE_MAX
//               consecutive denied cycles, and a_ready drops in that cycle.
//   undefined : A has strict priority; a_ready = !rst.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_a_valid/addr/data   pipeline writeback request
//   o_a_ready             port A accepted this cycle
//   i_b_valid/addr/data   long-latency result request
//   o_b_ready             FIFO not full
//   o_wen/o_waddr/o_wdata registered register-file write port
//   o_b_pending           FIFO holds at least one live entry
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int AW         = 5,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_a_valid,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [XLEN-1:0] i_a_data,
    output logic            o_a_ready,
    input  logic            i_b_valid,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [XLEN-1:0] i_b_data,
    output logic            o_b_ready,
    output logic            o_wen,
    output logic [AW-1:0]   o_waddr,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_b_pending
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage
    logic [AW-1:0]        r_buf_addr [BUF_DEPTH];
    logic [XLEN-1:0]      r_buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_buf_live;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;

    // Registered write port
    logic                 r_wen;
    logic [AW-1:0]        r_waddr;
    logic [XLEN-1:0]      r_wdata;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_head_live;
    logic                 w_force_b;
    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_squash;
    logic [BUF_DEPTH-1:0] w_live_next;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(BUF_DEPTH));
    assign w_head_live = !w_empty && r_buf_live[r_rptr];

    assign o_a_ready   = !i_rst && !w_force_b;
    assign o_b_ready   = !i_rst && !w_full;

    assign w_push      = i_b_valid && o_b_ready;
    assign w_grant_a   = i_a_valid && o_a_ready;
    // A is never granted while force_b is set, so this covers both the
    // normal "A idle" case and the forced case.
    assign w_grant_b   = !i_rst && w_head_live && !w_grant_a;
    // A dead head leaves without consuming the write slot.
    assign w_pop       = !i_rst && !w_empty && (!w_head_live || w_grant_b);
    assign w_squash    = w_grant_a && (i_a_addr != '0);

`ifdef WBARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;

    // Gated with head_live: a head squashed while the counter was climbing
    // must not force a grant of a dead entry.
    assign w_force_b = w_head_live && (r_starve == SW'(STARVE_MAX));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (w_grant_b || !w_head_live) begin
            r_starve <= '0;
        end else if (w_grant_a && (r_starve != SW'(STARVE_MAX))) begin
            r_starve <= r_starve + SW'(1);
        end
    end
`else
    assign w_force_b = 1'b0;
`endif

    // Squash first, then pop and push; the pushed slot is written last so a
    // same-cycle push is never squashed. Push and pop never share a slot
    // because a pop needs a non-empty FIFO and a push a non-full one.
    always_comb begin
        w_live_next = r_buf_live;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (w_squash && (r_buf_addr[i] == i_a_addr)) begin
                w_live_next[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_live_next[r_rptr] = 1'b0;
        end
        if (w_push) begin
            w_live_next[r_wptr] = (i_b_addr != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_live <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_buf_live <= w_live_next;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; the live bits decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_addr[r_wptr] <= i_b_addr;
            r_buf_data[r_wptr] <= i_b_data;
        end
    end

    // Idle cycles drive zero address/data so the register file's read-bypass
    // compare never matches a stale address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_squash) begin
            r_wen   <= 1'b1;
            r_waddr <= i_a_addr;
            r_wdata <= i_a_data;
        end else if (w_grant_b) begin
            r_wen   <= 1'b1;
            r_waddr <= r_buf_addr[r_rptr];
            r_wdata <= r_buf_data[r_rptr];
        end else begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end
    end

    assign o_wen       = r_wen;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_b_pending = |r_buf_live;

endmodule
